ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Parametrised N-channel arbiter that multiplexes several requesters, each speaking the existing cpu-side RAM protocol (memREN/memWEN/memaddr/memstore in; ramstate/ramload out), onto the single ram-side port of the memory model or SDRAM controller. Unlike the single-master interface, it supports configurable data/address width and channel count, round-robin fairness, per-channel status reporting, and a watchdog that converts a stalled access into ERROR. It sits between the tensor-core fetch/load/store clients and the RAM.

## Interface
- NCH, 4: number of requesting channels (≥2).
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- TIMEOUT, 64: max consecutive non-ACCESS cycles of a granted access before ERROR (≥2).

- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ch_ren  in  NCH  per-channel read enable.
- ch_wen  in  NCH  per-channel write enable.
- ch_addr  in  NCH×ADDR_W  per-channel address.
- ch_store  in  NCH×DATA_W  per-channel write data.
- ch_state  out  NCH×ramstate_t  per-channel status.
- ch_load  out  NCH×DATA_W  per-channel read data.
- ramREN, ramWEN  out  1  RAM enables.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramstate  in  ramstate_t  RAM status (FREE, BUSY, ACCESS, ERROR).
- ramload  in  DATA_W  RAM read data.

## Operation
- FSM states: ARB, GRANT, DONE.
- ARB: ram enables low. If any channel has ren|wen, choose first requester at or after rr_ptr (wrapping NCH-1→0), latch index in gnt, clear wd_cnt, go GRANT. Else stay.
- GRANT: drive ramREN/ramWEN/ramaddr/ramstore from channel gnt (combinational from live channel inputs). If channel asserts both ren and wen, only ramWEN is driven.
  - ramstate==ACCESS: go DONE.
  - ramstate==ERROR: go DONE.
  - wd_cnt==TIMEOUT-1 and no ACCESS/ERROR: go DONE with timeout flag set.
  - Granted channel drops both enables: abort, go ARB, rr_ptr ← gnt+1 (mod NCH).
  - Else wd_cnt increments (saturating).
- DONE: ram enables low for this one cycle; rr_ptr ← gnt+1 (mod NCH); clear timeout flag; go ARB.
- ch_state per channel i:
  - i==gnt in GRANT: ramstate passed through, except ERROR forced on the timeout cycle.
  - Otherwise, requesting: BUSY.
  - Otherwise, idle: FREE.
- ch_load[i] = ramload when i==gnt in GRANT, else 0.
- Width rule: wd_cnt is $clog2(TIMEOUT) bits; rr_ptr and gnt are $clog2(NCH) bits. NCH not a power of two wraps explicitly at NCH-1.

## Timing
- Reset (asynchronous): state=ARB, rr_ptr=0, gnt=0, wd_cnt=0. Outputs: ramREN=ramWEN=0, ramaddr=0, ramstore=0, ch_load=0, ch_state = BUSY for requesting channels, FREE otherwise.
- Reset asserted mid-GRANT: enables drop immediately. No completion is reported.
- Latency: request seen in ARB at cycle t → RAM driven at t+1. An ACCESS at cycle t+k is visible on ch_state/ch_load in that same cycle.
- Requester protocol: hold enables, addr, and data until ACCESS/ERROR is seen; deassert the following cycle.
- Back-to-back grants cost 2 overhead cycles (DONE, ARB); minimum 3 cycles per access with a zero-wait RAM.
- Starvation bound: a held request is granted within NCH-1 other accesses.
- A new request arriving during GRANT/DONE waits for ARB.

## Structure
- ram_pkg: ramstate_t (FREE, BUSY, ACCESS, ERROR) stays there; add arb_state_t (ARB, GRANT, DONE).
- Sub-module rr_picker: combinational first-set-bit-from-pointer search over NCH request bits; returns index and valid. Reused by future cache arbiters.
- Top-level: FSM, watchdog, muxes.

## Test plan
- Reset mid-GRANT with ch1 writing → ramWEN=0 during reset; after release, rr_ptr=0 and ch1 re-granted from ARB.
- Single requester, ch2 read 0x100, RAM returns ACCESS after 3 BUSY cycles with 0xDEADBEEF → ch_state[2]: BUSY×4, ACCESS×1; ch_load[2]=0xDEADBEEF on the ACCESS cycle; ramREN high from t+1 to t+4.
- All 4 channels request continuously, RAM zero-wait → grant order 0,1,2,3,0; each access spans 3 cycles; non-granted requesters read BUSY.
- Channel asserts both ren and wen → only ramWEN=1, ramREN=0.
- TIMEOUT=8, RAM stuck BUSY → ch_state=ERROR at GRANT cycle 8; RAM enables low next cycle; next channel then granted.
- Granted ch0 withdraws after 1 cycle → FSM back to ARB with no DONE cycle; ch1 granted next, rr_ptr=1.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types for the RAM-side protocol and the multi-channel arbiter.
package ram_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/ram_arbiter_rr_picker.sv
// Combinational round-robin search: first set request bit at or after ptr, wrapping at NCH-1.
module rr_picker #(
  parameter int NCH = 4,
  parameter int PW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  ptr,
  output logic [PW-1:0]  idx,
  output logic           vld
);

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NCH) s = s - NCH;
    return PW'(s);
  endfunction

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (req[wrap_add(ptr, k)]) begin
        idx = wrap_add(ptr, k);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// N-channel round-robin arbiter multiplexing cpu-side RAM requesters onto one RAM port.
module ram_arbiter
  import ram_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NCH-1:0]                ch_ren,
  input  logic [NCH-1:0]                ch_wen,
  input  logic [NCH-1:0][ADDR_W-1:0]    ch_addr,
  input  logic [NCH-1:0][DATA_W-1:0]    ch_store,
  output ramstate_t [NCH-1:0]           ch_state,
  output logic [NCH-1:0][DATA_W-1:0]    ch_load,
  output logic                          ramREN,
  output logic                          ramWEN,
  output logic [ADDR_W-1:0]             ramaddr,
  output logic [DATA_W-1:0]             ramstore,
  input  ramstate_t                     ramstate,
  input  logic [DATA_W-1:0]             ramload
);

  localparam int PW = $clog2(NCH);
  localparam int WW = $clog2(TIMEOUT);

  arb_state_t     state, state_nx;
  logic [PW-1:0]  gnt, rr_ptr, pick_idx;
  logic           pick_vld;
  logic [WW-1:0]  wd_cnt;
  logic [NCH-1:0] req;
  logic           gnt_req, done_hit, tmo_hit, abort_hit;

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] p);
    return (p == PW'(NCH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign req       = ch_ren | ch_wen;
  assign gnt_req   = req[gnt];
  assign done_hit  = (state == GRANT) && (ramstate == ACCESS || ramstate == ERROR);
  assign tmo_hit   = (state == GRANT) && !done_hit && (wd_cnt == WW'(TIMEOUT - 1));
  assign abort_hit = (state == GRANT) && !done_hit && !tmo_hit && !gnt_req;

  rr_picker #(.NCH(NCH), .PW(PW)) u_pick (
    .req (req),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ARB:     if (pick_vld) state_nx = GRANT;
      GRANT: begin
        if (done_hit || tmo_hit) state_nx = DONE;
        else if (abort_hit)      state_nx = ARB;
      end
      DONE:    state_nx = ARB;
      default: state_nx = ARB;
    endcase
  end

  // Grant index, fairness pointer and watchdog advance with the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt    <= '0;
      rr_ptr <= '0;
      wd_cnt <= '0;
    end else begin
      unique case (state)
        ARB: begin
          if (pick_vld) begin
            gnt    <= pick_idx;
            wd_cnt <= '0;
          end
        end
        GRANT: begin
          if (abort_hit) rr_ptr <= next_idx(gnt);
          else if (!done_hit && !tmo_hit && wd_cnt != '1) wd_cnt <= wd_cnt + 1'b1;
        end
        DONE:    rr_ptr <= next_idx(gnt);
        default: ;
      endcase
    end
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    for (int i = 0; i < NCH; i++) begin
      ch_state[i] = req[i] ? BUSY : FREE;
      ch_load[i]  = '0;
    end
    if (state == GRANT) begin
      // Write takes precedence when a channel raises both enables.
      ramWEN        = ch_wen[gnt];
      ramREN        = ch_ren[gnt] & ~ch_wen[gnt];
      ramaddr       = ch_addr[gnt];
      ramstore      = ch_store[gnt];
      ch_state[gnt] = tmo_hit ? ERROR : ramstate;
      ch_load[gnt]  = ramload;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small wait-state RAM model.
module tb_ram_arbiter;
  import ram_pkg::*;

  localparam int NCH = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NCH-1:0]         ren, wen;
  logic [NCH-1:0][AW-1:0] addr;
  logic [NCH-1:0][DW-1:0] store;
  ramstate_t [NCH-1:0]    chst;
  logic [NCH-1:0][DW-1:0] chld;
  logic                   rren, rwen;
  logic [AW-1:0]          raddr;
  logic [DW-1:0]          rstore;
  ramstate_t              rstate;
  logic [DW-1:0]          rload;

  logic       stuck;
  logic [7:0] wait_cfg;
  logic [7:0] busy_cnt = 8'd0;
  logic [DW-1:0] load_val;
  logic       ram_en;

  ram_arbiter #(.NCH(NCH), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .ch_ren   (ren),
    .ch_wen   (wen),
    .ch_addr  (addr),
    .ch_store (store),
    .ch_state (chst),
    .ch_load  (chld),
    .ramREN   (rren),
    .ramWEN   (rwen),
    .ramaddr  (raddr),
    .ramstore (rstore),
    .ramstate (rstate),
    .ramload  (rload)
  );

  // RAM answers ACCESS after wait_cfg BUSY cycles, or stays BUSY while stuck.
  assign ram_en = rren | rwen;
  always_comb begin
    rstate = FREE;
    if (ram_en) rstate = (!stuck && busy_cnt >= wait_cfg) ? ACCESS : BUSY;
  end
  assign rload = (rstate == ACCESS) ? load_val : '0;
  always_ff @(posedge clk)
    busy_cnt <= (ram_en && !stuck && rstate == BUSY) ? busy_cnt + 8'd1 : 8'd0;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    rst = 1'b1; ren = '0; wen = '0; addr = '0; store = '0;
    stuck = 1'b0; wait_cfg = 8'd0; load_val = 32'hDEADBEEF;
    tick; tick;
    chk("rst_ren", 64'(rren), 64'd0);
    chk("rst_wen", 64'(rwen), 64'd0);
    chk("rst_addr", 64'(raddr), 64'd0);
    chk("rst_store", 64'(rstore), 64'd0);
    chk("rst_load1", 64'(chld[1]), 64'd0);
    chk("rst_st0", 64'(chst[0]), 64'(FREE));
    ren[3] = 1'b1; settle;
    chk("rst_req_busy", 64'(chst[3]), 64'(BUSY));
    ren[3] = 1'b0;

    // Reset mid-GRANT with ch1 writing
    tick; rst = 1'b0; wen[1] = 1'b1; addr[1] = 32'h11; store[1] = 32'h55; stuck = 1'b1; settle;
    chk("t1_arb_wen", 64'(rwen), 64'd0);
    tick;
    chk("t1_gnt_wen", 64'(rwen), 64'd1);
    chk("t1_gnt_addr", 64'(raddr), 64'h11);
    chk("t1_gnt_store", 64'(rstore), 64'h55);
    rst = 1'b1; settle;
    chk("t1_rst_wen", 64'(rwen), 64'd0);
    chk("t1_rst_st1", 64'(chst[1]), 64'(BUSY));
    tick; rst = 1'b0; ren[3] = 1'b1; addr[3] = 32'h33; settle;
    chk("t1_rel_wen", 64'(rwen), 64'd0);
    tick; stuck = 1'b0; settle;
    chk("t1_regrant_addr", 64'(raddr), 64'h11);
    chk("t1_regrant_wen", 64'(rwen), 64'd1);
    chk("t1_regrant_ren", 64'(rren), 64'd0);
    chk("t1_st1", 64'(chst[1]), 64'(ACCESS));
    chk("t1_st3", 64'(chst[3]), 64'(BUSY));
    tick; wen[1] = 1'b0; ren[3] = 1'b0; settle;
    chk("t1_done_wen", 64'(rwen), 64'd0);
    tick;

    // Single requester with three wait states
    ren[2] = 1'b1; addr[2] = 32'h100; wait_cfg = 8'd3; settle;
    chk("t2_arb_st", 64'(chst[2]), 64'(BUSY));
    chk("t2_arb_ren", 64'(rren), 64'd0);
    for (int k = 1; k <= 3; k++) begin
      tick;
      chk("t2_busy_ren", 64'(rren), 64'd1);
      chk("t2_busy_addr", 64'(raddr), 64'h100);
      chk("t2_busy_st", 64'(chst[2]), 64'(BUSY));
    end
    tick;
    chk("t2_acc_st", 64'(chst[2]), 64'(ACCESS));
    chk("t2_acc_load", 64'(chld[2]), 64'hDEADBEEF);
    chk("t2_acc_ren", 64'(rren), 64'd1);
    chk("t2_other_load", 64'(chld[1]), 64'd0);
    tick; ren[2] = 1'b0; settle;
    chk("t2_done_ren", 64'(rren), 64'd0);
    tick;

    // Reset pointer, then all four channels request with a zero-wait RAM
    rst = 1'b1; tick; rst = 1'b0; wait_cfg = 8'd0;
    for (int i = 0; i < NCH; i++) begin
      ren[i] = 1'b1;
      addr[i] = 32'h1000 + 32'(i);
    end
    settle;
    for (int k = 0; k < 5; k++) begin
      int e;
      e = k % NCH;
      tick;
      chk("t3_gnt_addr", 64'(raddr), 64'h1000 + 64'(e));
      chk("t3_gnt_ren", 64'(rren), 64'd1);
      chk("t3_gnt_st", 64'(chst[e]), 64'(ACCESS));
      chk("t3_wait_st", 64'(chst[(e + 1) % NCH]), 64'(BUSY));
      tick;
      if (k == 4) ren = '0;
      settle;
      chk("t3_done_ren", 64'(rren), 64'd0);
      tick;
      chk("t3_arb_ren", 64'(rren), 64'd0);
      chk("t3_arb_st", 64'(chst[e]), (k == 4) ? 64'(FREE) : 64'(BUSY));
    end

    // Both enables from one channel
    ren[1] = 1'b1; wen[1] = 1'b1; addr[1] = 32'h44; settle;
    tick;
    chk("t4_wen", 64'(rwen), 64'd1);
    chk("t4_ren", 64'(rren), 64'd0);
    chk("t4_st", 64'(chst[1]), 64'(ACCESS));
    tick; ren[1] = 1'b0; wen[1] = 1'b0;
    tick;

    // Watchdog with RAM stuck BUSY
    ren[2] = 1'b1; addr[2] = 32'h200; ren[3] = 1'b1; addr[3] = 32'h300; stuck = 1'b1; settle;
    for (int g = 1; g <= TMO; g++) begin
      tick;
      chk("t5_addr", 64'(raddr), 64'h200);
      chk("t5_st2", 64'(chst[2]), (g == TMO) ? 64'(ERROR) : 64'(BUSY));
      chk("t5_st3", 64'(chst[3]), 64'(BUSY));
    end
    tick; ren[2] = 1'b0; settle;
    chk("t5_done_ren", 64'(rren), 64'd0);
    tick; stuck = 1'b0; settle;
    chk("t5_arb_ren", 64'(rren), 64'd0);
    tick;
    chk("t5_next_addr", 64'(raddr), 64'h300);
    chk("t5_next_ren", 64'(rren), 64'd1);
    chk("t5_next_st", 64'(chst[3]), 64'(ACCESS));
    tick; ren[3] = 1'b0;
    tick;

    // Granted ch0 withdraws: straight back to ARB, pointer moves to ch1
    ren[0] = 1'b1; addr[0] = 32'hA0; ren[1] = 1'b1; addr[1] = 32'hA1; stuck = 1'b1; settle;
    tick;
    chk("t6_gnt_addr", 64'(raddr), 64'hA0);
    chk("t6_gnt_ren", 64'(rren), 64'd1);
    tick; ren[0] = 1'b0; settle;
    chk("t6_drop_ren", 64'(rren), 64'd0);
    tick; ren[0] = 1'b1; settle;
    chk("t6_arb_ren", 64'(rren), 64'd0);
    chk("t6_arb_st0", 64'(chst[0]), 64'(BUSY));
    tick;
    chk("t6_ch1_ren", 64'(rren), 64'd1);
    chk("t6_ch1_addr", 64'(raddr), 64'hA1);
    stuck = 1'b0; settle;
    chk("t6_ch1_st", 64'(chst[1]), 64'(ACCESS));
    chk("t6_ch0_st", 64'(chst[0]), 64'(BUSY));
    tick; ren = '0;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
